// File: rtl/sseg_scan_controller_if.sv
// Write port of the seven-segment scan controller: a 16-bit hex value,
// per-digit decimal points and a leading-zero-blank flag, moved on a
// valid/ready handshake.
interface sseg_scan_controller_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic        wr_blank_lz;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_dp,
        output wr_blank_lz,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_dp,
        input  wr_blank_lz,
        output wr_ready
    );
endinterface

// File: rtl/sseg_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. A single pending buffer holds the next value; it moves into the
// active buffer only at a frame boundary or while idle, so a frame is never
// torn. All outputs are registered copies of the next-state decode.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | not scanning, display dark, pending value copied straight in
// S_ON    | digit idx lit for CLK_DIV cycles
// S_GUARD | all digits dark for GUARD cycles before the next digit
module sseg_scan_controller #(
    parameter int CLK_DIV = 1000,
    parameter int GUARD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    sseg_scan_controller_if.slave wr,
    output logic [3:0]            digit_o,
    output logic [6:0]            sseg_o,
    output logic                  dp_o,
    output logic                  frame_done_o
);

    localparam int CNT_MAX = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] ON_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] G_LAST  = CW'(GUARD - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GUARD} state_t;

    // Active-high abcdefg glyphs for hex digits.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h7E;
            4'h1: g = 7'h30;
            4'h2: g = 7'h6D;
            4'h3: g = 7'h79;
            4'h4: g = 7'h33;
            4'h5: g = 7'h5B;
            4'h6: g = 7'h5F;
            4'h7: g = 7'h70;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h7B;
            4'hA: g = 7'h77;
            4'hB: g = 7'h1F;
            4'hC: g = 7'h4E;
            4'hD: g = 7'h3D;
            4'hE: g = 7'h4F;
            default: g = 7'h47;
        endcase
        return g;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   act_data_q, act_data_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic          act_lz_q, act_lz_d;
    logic [15:0]   pend_data_q, pend_data_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_lz_q, pend_lz_d;
    logic          pend_full_q, pend_full_d;
    logic [3:0]    digit_q, digit_d;
    logic [6:0]    sseg_q, sseg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          boundary;
    logic [3:0]    nib;
    logic          upper_zero;
    logic          blank;

    assign wr.wr_ready  = ~pend_full_q;
    assign digit_o      = digit_q;
    assign sseg_o       = sseg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = frame_done_q;

    // Next-state: buffers, scan sequencing, and decode of the next display state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_lz_d    = act_lz_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_lz_d   = pend_lz_q;
        pend_full_d = pend_full_q;

        accept   = wr.wr_valid && !pend_full_q;
        boundary = (state_q == S_GUARD) && (idx_q == 2'd3) && (cnt_q == G_LAST);

        // A transfer needs a full pending buffer, so it can never coincide
        // with an accept; a write landing on the boundary waits a frame.
        if (pend_full_q && ((state_q == S_IDLE) || boundary)) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_lz_d    = pend_lz_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_data_d = wr.wr_data;
            pend_dp_d   = wr.wr_dp;
            pend_lz_d   = wr.wr_blank_lz;
            pend_full_d = 1'b1;
        end

        if (!enable_i) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ON;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                S_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = S_GUARD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_GUARD: begin
                    if (cnt_q == G_LAST) begin
                        state_d = S_ON;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        case (idx_d)
            2'd0: begin nib = act_data_d[3:0];   upper_zero = 1'b0;                     end
            2'd1: begin nib = act_data_d[7:4];   upper_zero = (act_data_d[15:4]  == '0); end
            2'd2: begin nib = act_data_d[11:8];  upper_zero = (act_data_d[15:8]  == '0); end
            default: begin nib = act_data_d[15:12]; upper_zero = (act_data_d[15:12] == '0); end
        endcase
        blank = act_lz_d && upper_zero;

        digit_d      = 4'hF;
        sseg_d       = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = (state_d == S_GUARD) && (idx_d == 2'd3) && (cnt_d == G_LAST);
        if (state_d == S_ON) begin
            // A blanked digit stays enabled when its decimal point is lit.
            if (!blank || act_dp_d[idx_d])
                digit_d[idx_d] = 1'b0;
            sseg_d = blank ? 7'h7F : ~glyph(nib);
            dp_d   = ~act_dp_d[idx_d];
        end
    end

    // State, buffers and registered outputs; reset darkens the display at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_lz_q     <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_lz_q    <= 1'b0;
            pend_full_q  <= 1'b0;
            digit_q      <= 4'hF;
            sseg_q       <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_lz_q     <= act_lz_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_lz_q    <= pend_lz_d;
            pend_full_q  <= pend_full_d;
            digit_q      <= digit_d;
            sseg_q       <= sseg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with CLK_DIV=4, GUARD=2 (24-cycle frame).
module tb_sseg_scan_controller;

    localparam int CLK_DIV = 4;
    localparam int GUARD   = 2;
    localparam int SLOT    = CLK_DIV + GUARD;
    localparam int FRAME   = 4 * SLOT;

    // Hand-computed per-slot expectations, packed {slot3,slot2,slot1,slot0}.
    localparam logic [15:0] DIG_ALL  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [27:0] SEG_12AF = {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000};
    localparam logic [27:0] SEG_0003 = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000110};
    localparam logic [27:0] SEG_0000 = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] digit;
    logic [6:0] sseg;
    logic       dp;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    sseg_scan_controller_if wr();

    sseg_scan_controller #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .wr           (wr),
        .digit_o      (digit),
        .sseg_o       (sseg),
        .dp_o         (dp),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_val(input logic [15:0] d, input logic [3:0] dpm, input logic lz);
        wr.wr_valid    = 1'b1;
        wr.wr_data     = d;
        wr.wr_dp       = dpm;
        wr.wr_blank_lz = lz;
        tick();
        wr.wr_valid    = 1'b0;
    endtask

    task automatic go_idle;
        enable = 1'b0;
        tick();
        tick();
    endtask

    // Leaves the bench at cycle 0 of the first frame showing the written value.
    task automatic start_scan(input logic [15:0] d, input logic [3:0] dpm, input logic lz);
        go_idle();
        write_val(d, dpm, lz);
        enable = 1'b1;
        tick();
    endtask

    // Expected {digit, sseg, dp, frame_done} for frame cycle c.
    function automatic logic [12:0] exp_vec(input int c, input logic [15:0] digs,
                                            input logic [27:0] segs, input logic [3:0] dpm);
        int   slot;
        int   pos;
        logic fd;
        slot = c / SLOT;
        pos  = c % SLOT;
        fd   = (c == FRAME - 1);
        if (pos < CLK_DIV)
            return {digs[slot*4 +: 4], segs[slot*7 +: 7], ~dpm[slot], fd};
        return {4'hF, 7'h7F, 1'b1, fd};
    endfunction

    task automatic test_reset;
        logic [13:0] got;
        rst = 1'b1;
        #1;
        got = {digit, sseg, dp, frame_done, wr.wr_ready};
        n_cmp++;
        if (got !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state got=%b exp=%b", got, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
        end
        #10;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_scan;
        logic [12:0] e;
        logic [12:0] got;
        start_scan(16'h12AF, 4'b0000, 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                e   = exp_vec(c, DIG_ALL, SEG_12AF, 4'b0000);
                got = {digit, sseg, dp, frame_done};
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL basic f=%0d c=%0d got=%b exp=%b", f, c, got, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_write_while_scanning;
        logic [12:0] e;
        logic [12:0] got;
        start_scan(16'h12AF, 4'b0000, 1'b0);
        for (int c = 0; c < FRAME; c++) begin
            e   = exp_vec(c, DIG_ALL, SEG_12AF, 4'b0000);
            got = {digit, sseg, dp, frame_done};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL midwrite_old c=%0d got=%b exp=%b", c, got, e);
            end
            n_cmp++;
            if (wr.wr_ready !== (c <= 7)) begin
                n_err++;
                $display("FAIL midwrite_ready c=%0d got=%b exp=%b", c, wr.wr_ready, (c <= 7));
            end
            if (c == 7) begin
                wr.wr_valid    = 1'b1;
                wr.wr_data     = 16'h0003;
                wr.wr_dp       = 4'b0000;
                wr.wr_blank_lz = 1'b0;
            end else if (c == 8) begin
                wr.wr_data     = 16'h5555;
            end else if (c == FRAME - 1) begin
                wr.wr_valid    = 1'b0;
            end
            tick();
        end
        n_cmp++;
        if (wr.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midwrite_ready_rise got=%b exp=1", wr.wr_ready);
        end
        for (int c = 0; c < FRAME; c++) begin
            e   = exp_vec(c, DIG_ALL, SEG_0003, 4'b0000);
            got = {digit, sseg, dp, frame_done};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL midwrite_new c=%0d got=%b exp=%b", c, got, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] e;
        logic [12:0] got;
        start_scan(16'h12AF, 4'b0000, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                e   = exp_vec(c, DIG_ALL, (f < 2) ? SEG_12AF : SEG_0003, 4'b0000);
                got = {digit, sseg, dp, frame_done};
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL boundary_write f=%0d c=%0d got=%b exp=%b", f, c, got, e);
                end
                if (f == 1 && c == 0) begin
                    n_cmp++;
                    if (wr.wr_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL boundary_ready got=%b exp=0", wr.wr_ready);
                    end
                end
                if (f == 0 && c == FRAME - 1) begin
                    wr.wr_valid    = 1'b1;
                    wr.wr_data     = 16'h0003;
                    wr.wr_dp       = 4'b0000;
                    wr.wr_blank_lz = 1'b0;
                end
                tick();
                wr.wr_valid = 1'b0;
            end
        end
    endtask

    task automatic test_leading_zero;
        logic [15:0] vals [3];
        logic [15:0] digs [3];
        logic [27:0] segs [3];
        logic [12:0] e;
        logic [12:0] got;
        vals[0] = 16'h0003;
        digs[0] = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
        segs[0] = {7'h7F, 7'h7F, 7'h7F, 7'b0000110};
        vals[1] = 16'h0000;
        digs[1] = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
        segs[1] = {7'h7F, 7'h7F, 7'h7F, 7'b0000001};
        vals[2] = 16'h0100;
        digs[2] = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
        segs[2] = {7'h7F, 7'b1001111, 7'b0000001, 7'b0000001};
        for (int v = 0; v < 3; v++) begin
            start_scan(vals[v], 4'b0000, 1'b1);
            for (int c = 0; c < FRAME; c++) begin
                e   = exp_vec(c, digs[v], segs[v], 4'b0000);
                got = {digit, sseg, dp, frame_done};
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL lz val=%h c=%0d got=%b exp=%b", vals[v], c, got, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_dp_on_blank;
        logic [12:0] e;
        logic [12:0] got;
        start_scan(16'h0003, 4'b0100, 1'b1);
        for (int c = 0; c < FRAME; c++) begin
            e   = exp_vec(c, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                          {7'h7F, 7'h7F, 7'h7F, 7'b0000110}, 4'b0100);
            got = {digit, sseg, dp, frame_done};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL dp_blank c=%0d got=%b exp=%b", c, got, e);
            end
            tick();
        end
    endtask

    task automatic test_enable_drop;
        logic [12:0] e;
        logic [12:0] got;
        start_scan(16'h12AF, 4'b0000, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (digit !== 4'b1110) begin
            n_err++;
            $display("FAIL en_before_drop got=%b exp=1110", digit);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {digit, sseg, dp, frame_done};
            n_cmp++;
            if (got !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL en_dark i=%0d got=%b exp=%b", i, got, {4'hF, 7'h7F, 1'b1, 1'b0});
            end
        end
        enable = 1'b1;
        tick();
        for (int c = 0; c < SLOT + 1; c++) begin
            e   = exp_vec(c, DIG_ALL, SEG_12AF, 4'b0000);
            got = {digit, sseg, dp, frame_done};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL en_restart c=%0d got=%b exp=%b", c, got, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_on;
        logic [13:0] got;
        logic [12:0] e;
        logic [12:0] g2;
        start_scan(16'h12AF, 4'b0000, 1'b0);
        for (int c = 0; c < 8; c++) tick();
        write_val(16'h0003, 4'b0000, 1'b0);
        n_cmp++;
        if (wr.wr_ready !== 1'b0 || digit !== 4'b1101) begin
            n_err++;
            $display("FAIL rst_setup ready=%b digit=%b exp ready=0 digit=1101", wr.wr_ready, digit);
        end
        rst = 1'b1;
        #1;
        got = {digit, sseg, dp, frame_done, wr.wr_ready};
        n_cmp++;
        if (got !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_async got=%b exp=%b", got, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
        end
        #1;
        rst = 1'b0;
        tick();
        for (int c = 0; c < FRAME; c++) begin
            e  = exp_vec(c, DIG_ALL, SEG_0000, 4'b0000);
            g2 = {digit, sseg, dp, frame_done};
            n_cmp++;
            if (g2 !== e) begin
                n_err++;
                $display("FAIL rst_discard c=%0d got=%b exp=%b", c, g2, e);
            end
            tick();
        end
    endtask

    initial begin
        wr.wr_valid    = 1'b0;
        wr.wr_data     = '0;
        wr.wr_dp       = '0;
        wr.wr_blank_lz = 1'b0;
        test_reset();
        test_basic_scan();
        test_write_while_scanning();
        test_back_to_back();
        test_leading_zero();
        test_dp_on_blank();
        test_enable_drop();
        test_reset_mid_on();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
